bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter built around the existing `shift_add` digit-adjust cell (add 3 when a digit is ≥5). It runs the shift-and-add-3 algorithm one bit per clock, using a small FSM and bit counter. It takes a binary value on a start strobe and returns packed BCD digits with a one-cycle done pulse. It sits between counters or arithmetic results and the 7-segment display drivers.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/shift_add.sv | 17 +
 rtl/bin2bcd_seq.sv | 85 ++++++++
 tb/tb_bin2bcd_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    // Bits needed for a counter that starts at WIDTH and counts down to 1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // True when DIGITS decimal digits can hold every WIDTH-bit value.
    function automatic bit bcd_fits(input int width, input int digits);
        longint lim;
        longint maxv;
        lim  = 1;
        maxv = (longint'(1) <<< width) - 1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
            if (lim > maxv) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/shift_add.sv
// Double-dabble digit adjust: digits 5..9 get +3 ahead of the left shift.
module shift_add (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pure lookup; values above 9 cannot occur in a legal conversion and pass through.
    always_comb begin
        dout = din;
        case (din)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: dout = din;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: dout = din + 4'd3;
            default:                      dout = din;
        endcase
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SW = 4 * DIGITS + WIDTH;
    localparam int CW = cnt_w(WIDTH);

    if (!bcd_fits(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t          state;
    logic [SW-1:0]   sreg;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   shifted;

    // Binary part is untouched by the adjust step; digit fields go through shift_add.
    assign adj[WIDTH-1:0] = sreg[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        shift_add u_sa (
            .din  (sreg[WIDTH + 4*i +: 4]),
            .dout (adj[WIDTH + 4*i +: 4])
        );
    end

    assign shifted = adj << 1;

    // Control FSM with datapath: load on start, adjust+shift per cycle, publish on last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= {{(4*DIGITS){1'b0}}, bin};
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sreg <= shifted;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bcd   <= shifted[SW-1 -: 4*DIGITS];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (8-bit/3-digit main instance, 4-bit/2-digit side instance).
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    typedef struct {
        logic [11:0] bcd;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    logic        start2;
    logic [3:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;

    int   cyc;
    int   tests;
    int   fails;
    int   inv_err;
    exp_t q[$];

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: at a negedge, cyc is the number of the most recent posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Issue a request for the main instance; expect done WIDTH edges after acceptance.
    task automatic issue(input logic [7:0] v, input logic [11:0] e, input bit expect_it);
        exp_t x;
        bin   = v;
        start = 1'b1;
        if (expect_it) begin
            x.bcd = e;
            x.due = cyc + 1 + 8;
            q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: pop the scoreboard on each done; also watch the digit-range invariant.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (rst_n && dut.state == CONV) begin
            for (int i = 0; i < 3; i++)
                if (dut.sreg[8 + 4*i +: 4] > 4'd9) inv_err++;
        end
        if (rst_n && dut2.state == CONV) begin
            for (int i = 0; i < 2; i++)
                if (dut2.sreg[4 + 4*i +: 4] > 4'd9) inv_err++;
        end
    end

    initial begin
        int nb;
        cyc     = 0;
        tests   = 0;
        fails   = 0;
        inv_err = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        bin     = 8'd0;
        start2  = 1'b0;
        bin2    = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // bin=0: busy high for exactly 8 cycles, then done with 000
        issue(8'd0, 12'h000, 1'b1);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk("busy_len", 32'(nb), 32'd8);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // 255 -> 255; bcd must hold afterwards while idle
        issue(8'd255, 12'h255, 1'b1);
        repeat (14) @(negedge clk);
        chk("bcd_hold", 32'(bcd), 32'h255);

        // Back-to-back sweep with start held high: accepts every 10 cycles
        start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            exp_t x;
            bin   = 8'(v);
            x.bcd = to_bcd(v);
            x.due = cyc + 1 + 8;
            q.push_back(x);
            repeat (10) @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Request during CONV is ignored
        issue(8'd99, 12'h099, 1'b1);
        repeat (2) @(negedge clk);
        issue(8'd7, 12'h007, 1'b0);
        repeat (14) @(negedge clk);

        // Start during the DONE cycle is dropped
        issue(8'd13, 12'h013, 1'b1);
        repeat (8) @(negedge clk);
        chk("done_cycle_seen", 32'(done), 32'd1);
        issue(8'd77, 12'h077, 1'b0);
        repeat (14) @(negedge clk);
        chk("drop_in_done_busy", 32'(busy), 32'd0);

        // Reset mid-conversion aborts and clears outputs at once
        issue(8'd200, 12'h200, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_bcd",  32'(bcd),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'd42, 12'h042, 1'b1);
        repeat (12) @(negedge clk);

        // Narrow instance: 4-bit 15 -> 8'h15 after 4 cycles
        bin2   = 4'd15;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bin2   = 4'd3;
        repeat (3) @(negedge clk);
        chk("w4_done_early", 32'(done2), 32'd0);
        @(negedge clk);
        chk("w4_done", 32'(done2), 32'd1);
        chk("w4_bcd",  32'(bcd2),  32'h15);
        repeat (3) @(negedge clk);

        chk("digit_invariant", 32'(inv_err), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
